// File: rtl/pong_pkg.sv
// Shared encodings and defaults for the pong game core.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PL_NONE = 2'd0,
    PL_P1   = 2'd1,
    PL_P2   = 2'd2
  } player_t;

  localparam logic DIR_TO_P1 = 1'b0;
  localparam logic DIR_TO_P2 = 1'b1;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  localparam int unsigned PERIOD0_DEF = 30_000_000;
  localparam int unsigned PERIOD1_DEF = 15_000_000;
  localparam int unsigned PERIOD2_DEF = 8_000_000;
  localparam int unsigned PERIOD3_DEF = 2_000_000;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Clearable ball-step counter; tc pulses on the last cycle of the selected period.
module pong_tick_gen
  import pong_pkg::*;
#(
  parameter int unsigned PERIOD0 = PERIOD0_DEF,
  parameter int unsigned PERIOD1 = PERIOD1_DEF,
  parameter int unsigned PERIOD2 = PERIOD2_DEF,
  parameter int unsigned PERIOD3 = PERIOD3_DEF
) (
  input  logic       CLK50,
  input  logic       RST,
  input  logic       run,
  input  logic       clr,
  input  logic [1:0] sel,
  output logic       tc
);

  localparam int unsigned PMAX  = max4(PERIOD0, PERIOD1, PERIOD2, PERIOD3);
  localparam int          CNT_W = (PMAX > 1) ? $clog2(PMAX) : 1;

  localparam logic [CNT_W-1:0] TC0 = CNT_W'(PERIOD0 - 1);
  localparam logic [CNT_W-1:0] TC1 = CNT_W'(PERIOD1 - 1);
  localparam logic [CNT_W-1:0] TC2 = CNT_W'(PERIOD2 - 1);
  localparam logic [CNT_W-1:0] TC3 = CNT_W'(PERIOD3 - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tc_val;

  always_comb begin
    tc_val = TC0;
    case (sel)
      2'd0:    tc_val = TC0;
      2'd1:    tc_val = TC1;
      2'd2:    tc_val = TC2;
      default: tc_val = TC3;
    endcase
  end

  // >= keeps the counter safe if the period shrinks without a clear
  assign tc = run && (cnt >= tc_val);

  always_ff @(posedge CLK50) begin
    if (RST || clr || !run || tc) cnt <= '0;
    else                          cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pong_engine.sv
// Two-player 1-D pong core: serve, swing/hit zones, lockout, scoring and match end.
module pong_engine
  import pong_pkg::*;
#(
  parameter int unsigned TRACK_LEN = 18,
  parameter int unsigned HIT_ZONE  = 2,
  parameter int unsigned SCORE_MAX = 11,
  parameter int unsigned PERIOD0   = PERIOD0_DEF,
  parameter int unsigned PERIOD1   = PERIOD1_DEF,
  parameter int unsigned PERIOD2   = PERIOD2_DEF,
  parameter int unsigned PERIOD3   = PERIOD3_DEF
) (
  input  logic                                CLK50,
  input  logic                                RST,
  input  logic                                en,
  input  logic [1:0]                          speed_init,
  input  logic                                p1_btn,
  input  logic                                p2_btn,
  output logic [$clog2(TRACK_LEN+2)-1:0]      ball_pos,
  output logic [TRACK_LEN-1:0]                ball_onehot,
  output logic [6:0]                          score1,
  output logic [6:0]                          score2,
  output logic [1:0]                          state,
  output logic [1:0]                          winner,
  output logic [1:0]                          speed
);

  localparam int PW = $clog2(TRACK_LEN + 2);

  localparam logic [PW-1:0] POS_FIRST = PW'(1);
  localparam logic [PW-1:0] POS_LAST  = PW'(TRACK_LEN);
  localparam logic [PW-1:0] POS_OUT2  = PW'(TRACK_LEN + 1);
  localparam logic [PW-1:0] HZ1_HI    = PW'(HIT_ZONE);
  localparam logic [PW-1:0] HZ2_LO    = PW'(TRACK_LEN - HIT_ZONE + 1);
  localparam logic [6:0]    SCORE_PRE = 7'(SCORE_MAX - 1);

  function automatic logic [TRACK_LEN-1:0] onehot_of(input logic [PW-1:0] p);
    logic [TRACK_LEN-1:0] v;
    v = '0;
    for (int i = 0; i < int'(TRACK_LEN); i++)
      if (p == PW'(i + 1)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] pos_step(input logic [PW-1:0] p, input logic d);
    return (d == DIR_TO_P2) ? p + PW'(1) : p - PW'(1);
  endfunction

  function automatic logic [1:0] spd_inc(input logic [1:0] s);
    return (s == SPEED_MAX) ? s : s + 2'd1;
  endfunction

  state_t      st;
  player_t     server;
  logic        dir;
  logic [1:0]  saved_speed;
  logic        p1_q, p2_q;
  logic        lock1, lock2;

  logic rst_all, in_play, p1_press, p2_press, miss1, miss2;
  logic swing1, swing2, hit1, hit2, early1, early2, tick;

  assign state    = st;
  assign rst_all  = RST || !en;
  assign in_play  = (st == ST_PLAY);
  assign p1_press = p1_btn & ~p1_q;
  assign p2_press = p2_btn & ~p2_q;

  // Out-of-bounds positions score first, so a coincident press is discarded
  assign miss1  = in_play && (ball_pos == '0);
  assign miss2  = in_play && (ball_pos == POS_OUT2);
  assign swing1 = in_play && !miss1 && !miss2 && p1_press && (dir == DIR_TO_P1) && !lock1;
  assign swing2 = in_play && !miss1 && !miss2 && p2_press && (dir == DIR_TO_P2) && !lock2;
  assign hit1   = swing1 && (ball_pos <= HZ1_HI);
  assign early1 = swing1 && (ball_pos >  HZ1_HI);
  assign hit2   = swing2 && (ball_pos >= HZ2_LO);
  assign early2 = swing2 && (ball_pos <  HZ2_LO);

  pong_tick_gen #(
    .PERIOD0 (PERIOD0),
    .PERIOD1 (PERIOD1),
    .PERIOD2 (PERIOD2),
    .PERIOD3 (PERIOD3)
  ) u_tick (
    .CLK50 (CLK50),
    .RST   (rst_all),
    .run   (in_play),
    .clr   (hit1 || hit2 || miss1 || miss2),
    .sel   (speed),
    .tc    (tick)
  );

  always_ff @(posedge CLK50) begin
    if (rst_all) begin
      st          <= ST_IDLE;
      ball_pos    <= POS_FIRST;
      ball_onehot <= onehot_of(POS_FIRST);
      dir         <= DIR_TO_P2;
      score1      <= '0;
      score2      <= '0;
      winner      <= PL_NONE;
      speed       <= '0;
      saved_speed <= '0;
      server      <= PL_P1;
      p1_q        <= 1'b1;
      p2_q        <= 1'b1;
      lock1       <= 1'b0;
      lock2       <= 1'b0;
    end else begin
      p1_q <= p1_btn;
      p2_q <= p2_btn;
      case (st)
        ST_IDLE: begin
          speed       <= speed_init;
          saved_speed <= speed_init;
          st          <= ST_SERVE;
        end
        ST_SERVE: begin
          speed <= saved_speed;
          if ((server == PL_P1 && p1_press) || (server == PL_P2 && p2_press))
            st <= ST_PLAY;
        end
        ST_PLAY: begin
          if (miss1 || miss2) begin
            lock1 <= 1'b0;
            lock2 <= 1'b0;
            if (miss1) begin
              score2      <= score2 + 7'd1;
              ball_pos    <= POS_FIRST;
              ball_onehot <= onehot_of(POS_FIRST);
              dir         <= DIR_TO_P2;
              server      <= PL_P1;
              if (score2 == SCORE_PRE) begin
                st     <= ST_OVER;
                winner <= PL_P2;
              end else begin
                st <= ST_SERVE;
              end
            end else begin
              score1      <= score1 + 7'd1;
              ball_pos    <= POS_LAST;
              ball_onehot <= onehot_of(POS_LAST);
              dir         <= DIR_TO_P1;
              server      <= PL_P2;
              if (score1 == SCORE_PRE) begin
                st     <= ST_OVER;
                winner <= PL_P1;
              end else begin
                st <= ST_SERVE;
              end
            end
          end else if (hit1 || hit2) begin
            // Outer-position returns reverse without speeding up
            dir   <= hit1 ? DIR_TO_P2 : DIR_TO_P1;
            lock1 <= 1'b0;
            lock2 <= 1'b0;
            if ((hit1 && ball_pos != POS_FIRST) || (hit2 && ball_pos != POS_LAST))
              speed <= spd_inc(speed);
          end else begin
            if (early1) lock1 <= 1'b1;
            if (early2) lock2 <= 1'b1;
            if (tick) begin
              ball_pos    <= pos_step(ball_pos, dir);
              ball_onehot <= onehot_of(pos_step(ball_pos, dir));
            end
          end
        end
        ST_OVER: begin
          if (p1_press || p2_press) begin
            score1 <= '0;
            score2 <= '0;
            winner <= PL_NONE;
            speed  <= '0;
            st     <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
